cdb_arbiter: RTL and testbench

- Responder side of the per-register-file CDB request handshake (req_if valid/ready) that execution units such as the load/store unit use to win a result-broadcast slot.
- One instance per register file (GPR, FPR).
- Arbitrates round-robin among N_REQ requesters and captures the winner's tag in the grant cycle. One cycle later it drives the broadcast cdb (valid/tag/data), taking data from the winner's registered result output.
- Supports pipeline flush on branch mispredict.

---
 rtl/cdb_arbiter.sv | 96 +++++++++
 tb/tb_cdb_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Round-robin responder for the per-register-file common data bus (CDB).
// Execution units raise req_valid to ask for a broadcast slot. One winner is
// granted combinationally through req_ready, and its tag is captured on that
// edge. One cycle later the winner's registered result is broadcast on the
// cdb_* outputs. A flush squashes both the current grant and the pending
// broadcast.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   req_valid    [N_REQ]             per-unit slot request
//   req_ready    [N_REQ]             per-unit grant, one-hot or zero
//   req_tag      [N_REQ*TAG_WIDTH]   per-unit ROB tag, sampled in grant cycle
//   req_data     [N_REQ*DATA_WIDTH]  per-unit result, read the cycle after grant
//   flush        squash grant and in-flight broadcast
//   cdb_valid/cdb_tag/cdb_data       broadcast (tag/data zero when not valid)
//   grant_count  [16]                saturating count of grants since reset
module cdb_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TAG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*TAG_WIDTH-1:0]    req_tag,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                          flush,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  output logic [15:0]                   grant_count
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]         rr_ptr, pend_idx, grant_idx, cand;
  logic                  pend_valid, grant;
  logic [TAG_WIDTH-1:0]  pend_tag, grant_tag;
  logic [DATA_WIDTH-1:0] pend_data;

  // Rotating scan starting at rr_ptr. The modulo keeps every candidate
  // index below N_REQ, including for non-power-of-two N_REQ.
  always_comb begin
    req_ready = '0;
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!reset && !flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = PW'((int'(rr_ptr) + k) % N_REQ);
        if (!grant && req_valid[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant) req_ready[grant_idx] = 1'b1;
    end
  end

  // Winner tag mux (grant cycle) and pending-unit data mux (broadcast cycle).
  always_comb begin
    grant_tag = '0;
    pend_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == PW'(i)) grant_tag = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      if (pend_idx == PW'(i))  pend_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      pend_valid  <= 1'b0;
      pend_idx    <= '0;
      pend_tag    <= '0;
      grant_count <= '0;
    end else begin
      // grant is already forced low during flush, so this also squashes
      // the slot and leaves rr_ptr untouched.
      pend_valid <= grant;
      if (grant) begin
        pend_idx <= grant_idx;
        pend_tag <= grant_tag;
        rr_ptr   <= (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
        if (grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
      end
    end
  end

  assign cdb_valid = pend_valid && !flush;
  assign cdb_tag   = cdb_valid ? pend_tag  : '0;
  assign cdb_data  = cdb_valid ? pend_data : '0;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic            flush;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [15:0]     grant_count;

  cdb_arbiter #(.N_REQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_data(req_data), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  // unit: index whose result must be on the CDB this cycle, -1 = idle CDB,
  // -2 = CDB not checked in this row.
  typedef struct {
    logic         rst;
    logic         fl;
    logic [N-1:0] valid;
    logic [N-1:0] ready;
    int           unit;
    logic [15:0]  cnt;
  } vec_t;

  vec_t          vecs[$];
  logic [TW-1:0] tags[N];
  logic [DW-1:0] dat[N];
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic add(input logic rst, input logic fl, input logic [N-1:0] v,
                     input logic [N-1:0] r, input int u, input logic [15:0] c);
    vec_t t;
    t.rst = rst; t.fl = fl; t.valid = v; t.ready = r; t.unit = u; t.cnt = c;
    vecs.push_back(t);
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = tags[i];
      req_data[i*DW +: DW] = dat[i];
    end
  endtask

  task automatic check(input string name, input vec_t v);
    logic          ev;
    logic [TW-1:0] et;
    logic [DW-1:0] ed;
    n_vec++;
    ev = (v.unit >= 0);
    et = ev ? tags[v.unit] : '0;
    ed = ev ? dat[v.unit]  : '0;
    if (req_ready !== v.ready) begin
      n_bad++; $display("FAIL %s req_ready got %b want %b", name, req_ready, v.ready);
    end
    if (grant_count !== v.cnt) begin
      n_bad++; $display("FAIL %s grant_count got %0d want %0d", name, grant_count, v.cnt);
    end
    if (v.unit != -2) begin
      if (cdb_valid !== ev) begin
        n_bad++; $display("FAIL %s cdb_valid got %b want %b", name, cdb_valid, ev);
      end
      if (cdb_tag !== et) begin
        n_bad++; $display("FAIL %s cdb_tag got %h want %h", name, cdb_tag, et);
      end
      if (cdb_data !== ed) begin
        n_bad++; $display("FAIL %s cdb_data got %h want %h", name, cdb_data, ed);
      end
    end
  endtask

  initial begin
    vec_t hv;
    tags[0] = 5'h10; tags[1] = 5'h11; tags[2] = 5'h0B; tags[3] = 5'h13;
    dat[0] = 32'hA000_0000; dat[1] = 32'hB111_1111;
    dat[2] = 32'hDEAD_BEEF; dat[3] = 32'hC333_3333;
    drive_data();
    reset = 1'b1; flush = 1'b0; req_valid = '0;

    // idle after reset
    add(0,0,4'b0000,4'b0000,-1,0);
    add(0,0,4'b0000,4'b0000,-1,0);
    add(0,0,4'b0000,4'b0000,-1,0);
    // single request to unit 2, broadcast next cycle
    add(0,0,4'b0100,4'b0100,-1,0);
    add(0,0,4'b0000,4'b0000, 2,1);
    // rr_ptr=3 with only 0,1 requesting: wrap to 0, then 1
    add(0,0,4'b0011,4'b0001,-1,1);
    add(0,0,4'b0011,4'b0010, 0,2);
    add(0,0,4'b0000,4'b0000, 1,3);
    // back-to-back grants from rr_ptr=2
    add(0,0,4'b1111,4'b0100,-1,3);
    add(0,0,4'b1111,4'b1000, 2,4);
    add(0,0,4'b1111,4'b0001, 3,5);
    add(0,0,4'b1111,4'b0010, 0,6);
    // reset mid-stream
    add(1,0,4'b1111,4'b0000,-2,7);
    // full contention from rr_ptr=0 for 8 cycles
    add(0,0,4'b1111,4'b0001,-1,0);
    add(0,0,4'b1111,4'b0010, 0,1);
    add(0,0,4'b1111,4'b0100, 1,2);
    add(0,0,4'b1111,4'b1000, 2,3);
    add(0,0,4'b1111,4'b0001, 3,4);
    add(0,0,4'b1111,4'b0010, 0,5);
    add(0,0,4'b1111,4'b0100, 1,6);
    add(0,0,4'b1111,4'b1000, 2,7);
    add(0,0,4'b0000,4'b0000, 3,8);
    // grant unit 1, flush next cycle; resume from rr_ptr=2
    add(0,0,4'b0010,4'b0010,-1,8);
    add(0,1,4'b1111,4'b0000,-1,9);
    add(0,0,4'b1111,4'b0100,-1,9);
    add(0,1,4'b0000,4'b0000,-1,10);
    // reset together with flush: reset wins
    add(1,1,4'b1111,4'b0000,-1,10);
    add(0,0,4'b1010,4'b0010,-1,0);
    add(0,0,4'b1010,4'b1000, 1,1);
    add(0,0,4'b0000,4'b0000, 3,2);

    @(negedge clk);
    @(negedge clk);
    foreach (vecs[i]) begin
      reset = vecs[i].rst; flush = vecs[i].fl; req_valid = vecs[i].valid;
      #2;
      check($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Data is read from the unit the cycle after the grant, not the grant cycle.
    reset = 1'b0; flush = 1'b0; req_valid = 4'b1000;
    #2;
    hv.rst = 0; hv.fl = 0; hv.valid = 4'b1000; hv.ready = 4'b1000; hv.unit = -1; hv.cnt = 2;
    check("late_data_grant", hv);
    @(negedge clk);
    req_valid = 4'b0000;
    dat[3] = 32'h1234_5678;
    drive_data();
    #2;
    hv.valid = 4'b0000; hv.ready = 4'b0000; hv.unit = 3; hv.cnt = 3;
    check("late_data_bcast", hv);
    @(negedge clk);

    // Same slot flushed in its broadcast cycle while another unit requests.
    req_valid = 4'b0001;
    #2;
    hv.valid = 4'b0001; hv.ready = 4'b0001; hv.unit = -1; hv.cnt = 3;
    check("flush_bcast_grant", hv);
    @(negedge clk);
    flush = 1'b1; req_valid = 4'b0001;
    #2;
    hv.ready = 4'b0000; hv.unit = -1; hv.cnt = 4;
    check("flush_bcast_squash", hv);
    @(negedge clk);
    flush = 1'b0; req_valid = 4'b0011;
    #2;
    hv.valid = 4'b0011; hv.ready = 4'b0010; hv.unit = -1; hv.cnt = 4;
    check("flush_resume_rr1", hv);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
